// File: rtl/spi_slave_regs.sv
// SPI mode-0 register responder, fully oversampled on clk.
// One 16-bit frame per select window: {rw, addr[6:0], data[7:0]}, MSB first.
module spi_slave_regs #(
  parameter logic [7:0]  VERSION    = 8'h31,
  parameter logic [31:0] CTRL_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        spi_sclk,
  input  logic        spi_ss_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic [31:0] ctrl_out,
  input  logic [31:0] status_in,
  output logic        wr_strobe,
  output logic [6:0]  wr_addr,
  output logic        frame_abort
);

  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, DATA = 2'd2, DONE = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [2:0]  sclk_q, sclk_d;
  logic [2:0]  ss_q, ss_d;
  logic [1:0]  mosi_q, mosi_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic        rw_q, rw_d;
  logic [6:0]  addr_q, addr_d;
  logic [7:0]  rd_shift_q, rd_shift_d;
  logic        miso_q, miso_d;
  logic [31:0] ctrl_q, ctrl_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic [6:0]  wr_addr_q, wr_addr_d;
  logic        abort_q, abort_d;

  logic       sclk_rise, sclk_fall, ss_sync, ss_fall, mosi_s;
  logic [6:0] cmd_addr;
  logic [7:0] data_byte;

  // Index 0 = metastable stage, 1 = synced value, 2 = previous synced value.
  always_comb begin
    sclk_d = {sclk_q[1:0], spi_sclk};
    ss_d   = {ss_q[1:0], spi_ss_n};
    mosi_d = {mosi_q[0], spi_mosi};
  end

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign ss_sync   = ss_q[1];
  assign ss_fall   = ~ss_q[1] & ss_q[2];
  assign mosi_s    = mosi_q[1];
  assign cmd_addr  = {shift_q[5:0], mosi_s};
  assign data_byte = {shift_q, mosi_s};

  function automatic logic [7:0] read_byte(input logic [6:0] a, input logic [31:0] ctrl,
                                           input logic [31:0] stat);
    logic [7:0] r;
    r = 8'h00;
    if (a < 7'd4)        r = ctrl[{a[1:0], 3'b000} +: 8];
    else if (a < 7'd8)   r = stat[{a[1:0], 3'b000} +: 8];
    else if (a == 7'h7F) r = VERSION;
    return r;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sclk_q      <= 3'b000;
      ss_q        <= 3'b111;
      mosi_q      <= 2'b00;
      cnt_q       <= 3'd0;
      shift_q     <= 7'd0;
      rw_q        <= 1'b0;
      addr_q      <= 7'd0;
      rd_shift_q  <= 8'd0;
      miso_q      <= 1'b0;
      ctrl_q      <= CTRL_RESET;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 7'd0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_q      <= sclk_d;
      ss_q        <= ss_d;
      mosi_q      <= mosi_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      rd_shift_q  <= rd_shift_d;
      miso_q      <= miso_d;
      ctrl_q      <= ctrl_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      abort_q     <= abort_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (ss_fall) state_d = CMD;
      CMD:  if (ss_sync) state_d = IDLE;
            else if (sclk_rise && cnt_q == 3'd7) state_d = DATA;
      DATA: if (ss_sync) state_d = IDLE;
            else if (sclk_rise && cnt_q == 3'd7) state_d = DONE;
      DONE: if (ss_sync) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    rd_shift_d  = rd_shift_q;
    miso_d      = 1'b0;
    ctrl_d      = ctrl_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    abort_d     = 1'b0;
    case (state_q)
      IDLE: begin
        // A rise coinciding with the select edge is already bit 15.
        if (ss_fall) begin
          cnt_d = 3'd0;
          if (sclk_rise) begin
            shift_d = {shift_q[5:0], mosi_s};
            cnt_d   = 3'd1;
          end
        end
      end
      CMD: begin
        if (ss_sync) begin
          abort_d = 1'b1;
        end else if (sclk_rise) begin
          shift_d = {shift_q[5:0], mosi_s};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            rw_d       = shift_q[6];
            addr_d     = cmd_addr;
            rd_shift_d = read_byte(cmd_addr, ctrl_q, status_in);
          end
        end
      end
      DATA: begin
        if (ss_sync) begin
          abort_d = 1'b1;
        end else begin
          miso_d = miso_q;
          if (sclk_rise) begin
            shift_d = {shift_q[5:0], mosi_s};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7 && !rw_q && addr_q[6:2] == 5'd0) begin
              ctrl_d[{addr_q[1:0], 3'b000} +: 8] = data_byte;
              wr_strobe_d = 1'b1;
              wr_addr_d   = addr_q;
            end
          end
          if (sclk_fall) begin
            miso_d     = rd_shift_q[7];
            rd_shift_d = {rd_shift_q[6:0], 1'b0};
          end
        end
      end
      default: ;
    endcase
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = ~ss_sync;
  assign ctrl_out    = ctrl_q;
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign frame_abort = abort_q;

endmodule

// File: tb/tb_spi_slave_regs.sv
// Scoreboard bench for spi_slave_regs: bit-banged SPI master at clk/10,
// queued expectations for read bytes and write commits.
module tb_spi_slave_regs;

  localparam logic [31:0] CTRL_RST = 32'h4433_2211;

  logic        clk;
  logic        reset_n;
  logic        spi_sclk, spi_ss_n, spi_mosi;
  logic        spi_miso, spi_miso_oe;
  logic [31:0] ctrl_out;
  logic [31:0] status_in;
  logic        wr_strobe;
  logic [6:0]  wr_addr;
  logic        frame_abort;

  spi_slave_regs #(.VERSION(8'h31), .CTRL_RESET(CTRL_RST)) dut (
    .clk(clk), .reset_n(reset_n),
    .spi_sclk(spi_sclk), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .ctrl_out(ctrl_out), .status_in(status_in),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .frame_abort(frame_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int abort_cnt = 0;
  logic [31:0] ctrl_model;
  logic [7:0]  rd_q[$];
  logic [14:0] wr_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Write-commit monitor: each strobe must match the oldest expected write.
  always @(negedge clk) begin
    logic [14:0] e;
    if (reset_n && wr_strobe) begin
      if (wr_q.size() == 0) begin
        check("wr_unexpected", {25'd0, wr_addr}, 32'hFFFF_FFFF);
      end else begin
        e = wr_q.pop_front();
        ctrl_model[{e[9:8], 3'b000} +: 8] = e[7:0];
        check("wr_addr", {25'd0, wr_addr}, {25'd0, e[14:8]});
        check("wr_ctrl", ctrl_out, ctrl_model);
      end
    end
    if (frame_abort) abort_cnt++;
  end

  task automatic spi_bit(input logic b, output logic m);
    spi_mosi = b;
    repeat (5) @(negedge clk);
    spi_sclk = 1'b1;
    m = spi_miso;
    repeat (5) @(negedge clk);
    spi_sclk = 1'b0;
  endtask

  task automatic spi_xfer(input logic [15:0] tx, input int nbits, input bit tight,
                          input logic [31:0] st_after, output logic [7:0] rx,
                          output logic [7:0] cmd_m, output logic ext_m);
    logic b, m;
    rx = 8'h00; cmd_m = 8'h00; ext_m = 1'b0;
    if (!tight) begin
      spi_ss_n = 1'b0;
      repeat (6) @(negedge clk);
    end
    for (int i = 0; i < nbits; i++) begin
      b = (i < 16) ? tx[15 - i] : 1'b1;
      if (tight && i == 0) begin
        spi_mosi = b; spi_ss_n = 1'b0; spi_sclk = 1'b1;
        m = spi_miso;
        repeat (5) @(negedge clk);
        spi_sclk = 1'b0;
      end else begin
        spi_bit(b, m);
      end
      if (i < 8)       cmd_m[7 - i] = m;
      else if (i < 16) rx[15 - i] = m;
      else             ext_m = ext_m | m;
      if (i == 7) status_in = st_after;
    end
    repeat (6) @(negedge clk);
    check("oe_in_frame", {31'd0, spi_miso_oe}, 32'd1);
    spi_ss_n = 1'b1;
    repeat (6) @(negedge clk);
    check("oe_idle", {31'd0, spi_miso_oe}, 32'd0);
  endtask

  task automatic do_frame(input logic [15:0] tx, input int nbits, input bit tight,
                          input logic [31:0] st_after, input logic [7:0] exp_rx);
    logic [7:0] rx, cmd_m, exp;
    logic ext_m;
    rd_q.push_back(exp_rx);
    spi_xfer(tx, nbits, tight, st_after, rx, cmd_m, ext_m);
    exp = rd_q.pop_front();
    $display("frame tx=%h bits=%0d tight=%0d rx=%h exp=%h ctrl=%h", tx, nbits, tight, rx, exp, ctrl_out);
    check("rd_byte", {24'd0, rx}, {24'd0, exp});
    check("cmd_miso", {24'd0, cmd_m}, 32'd0);
    if (nbits > 16) check("extra_miso", {31'd0, ext_m}, 32'd0);
    check("wr_pending", wr_q.size(), 32'd0);
    check("ctrl", ctrl_out, ctrl_model);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic m;
    reset_n = 1'b0; spi_sclk = 1'b0; spi_ss_n = 1'b1; spi_mosi = 1'b0;
    status_in = 32'h0;
    ctrl_model = CTRL_RST;
    repeat (3) @(negedge clk);
    check("rst_ctrl", ctrl_out, CTRL_RST);
    check("rst_miso", {31'd0, spi_miso}, 32'd0);
    check("rst_oe", {31'd0, spi_miso_oe}, 32'd0);
    check("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
    check("rst_wr_addr", {25'd0, wr_addr}, 32'd0);
    check("rst_abort", {31'd0, frame_abort}, 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Write 0x02 <- A5, echo returns the old byte.
    wr_q.push_back({7'h02, 8'hA5});
    do_frame(16'h02A5, 16, 1'b0, 32'h0, 8'h33);
    check("wr_addr_02", {25'd0, wr_addr}, 32'h02);
    do_frame(16'hFF00, 16, 1'b0, 32'h0, 8'h31);
    // Status read; status changes after the command byte must not matter.
    status_in = 32'h1234_5678;
    do_frame(16'h8500, 16, 1'b0, 32'hDEAD_BEEF, 8'h56);
    // Ignored writes: read-only status and unmapped address.
    do_frame(16'h05FF, 16, 1'b0, 32'hDEAD_BEEF, 8'hBE);
    do_frame(16'h4011, 16, 1'b0, 32'hDEAD_BEEF, 8'h00);
    check("wr_addr_hold", {25'd0, wr_addr}, 32'h02);
    // Abort after 12 bits: only the top nibble of the echo was clocked out.
    do_frame(16'h015A, 12, 1'b0, 32'hDEAD_BEEF, 8'h20);
    check("abort_cnt", abort_cnt, 32'd1);
    wr_q.push_back({7'h01, 8'h5A});
    do_frame(16'h015A, 16, 1'b0, 32'hDEAD_BEEF, 8'h22);
    // Extra SCLK cycles after the frame are ignored.
    wr_q.push_back({7'h03, 8'h77});
    do_frame(16'h0377, 20, 1'b0, 32'hDEAD_BEEF, 8'h44);
    // Select and first rise arrive together.
    wr_q.push_back({7'h00, 8'hC3});
    do_frame(16'h00C3, 16, 1'b1, 32'hDEAD_BEEF, 8'h11);
    do_frame(16'h8000, 16, 1'b0, 32'hDEAD_BEEF, 8'hC3);
    check("ctrl_final", ctrl_out, 32'h77A5_5AC3);

    // Reset in the middle of a read.
    spi_ss_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      logic [15:0] t;
      t = 16'h8300;
      spi_bit(t[15 - i], m);
    end
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    $display("reset mid-read ctrl=%h oe=%0d", ctrl_out, spi_miso_oe);
    check("mid_rst_oe", {31'd0, spi_miso_oe}, 32'd0);
    check("mid_rst_miso", {31'd0, spi_miso}, 32'd0);
    check("mid_rst_ctrl", ctrl_out, CTRL_RST);
    spi_ss_n = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    ctrl_model = CTRL_RST;
    repeat (4) @(negedge clk);
    do_frame(16'h8000, 16, 1'b0, 32'hDEAD_BEEF, CTRL_RST[7:0]);
    check("abort_cnt_end", abort_cnt, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
